// File: rtl/imem_bank_xbar.sv
// Crossbar from nPORTs instruction fetch ports to nBANKs synchronous ROM banks with a round-robin
// arbiter per bank and one-cycle response latency. Optional IMEM_BANK_XBAR_MERGE_EN merges same-address fetches.
module imem_bank_xbar #(
  parameter int unsigned nPORTs = 3,
  parameter int unsigned nBANKs = 4,
  parameter int unsigned ROW_W  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [nPORTs-1:0]                          req_vld,
  input  logic [nPORTs-1:0][ROW_W+$clog2(nBANKs)-1:0] req_addr,
  output logic [nPORTs-1:0]                          req_rdy,
  output logic [nPORTs-1:0]                          rsp_vld,
  output logic [nPORTs-1:0][DATA_W-1:0]              rsp_data,
  output logic [nBANKs-1:0]                          bank_en,
  output logic [nBANKs-1:0][ROW_W-1:0]               bank_row,
  input  logic [nBANKs-1:0][DATA_W-1:0]              bank_rdata
);

  localparam int unsigned BankW = $clog2(nBANKs);
  localparam int unsigned AddrW = ROW_W + BankW;
  localparam int unsigned PtrW  = (nPORTs > 1) ? $clog2(nPORTs) : 1;

  logic [nBANKs-1:0][PtrW-1:0]   ptrQ, ptrD;
  logic [nBANKs-1:0][nPORTs-1:0] grant;
  logic [nPORTs-1:0]             rspVldQ;
  logic [nPORTs-1:0][BankW-1:0]  rspBankQ;
  logic [nPORTs-1:0][DATA_W-1:0] dataHoldQ;
  logic                          found;
  int                            win;
  int                            idx;

  // Per-bank round-robin search starting at ptrQ[b]; grants are suppressed while in reset.
  always_comb begin
    grant    = '0;
    bank_en  = '0;
    bank_row = '0;
    ptrD     = ptrQ;
    found    = 1'b0;
    win      = 0;
    idx      = 0;
    for (int b = 0; b < int'(nBANKs); b++) begin
      found = 1'b0;
      win   = 0;
      for (int off = 0; off < int'(nPORTs); off++) begin
        idx = (int'(ptrQ[b]) + off) % int'(nPORTs);
        if (!found && req_vld[idx] && (req_addr[idx][BankW-1:0] == BankW'(b))) begin
          found = 1'b1;
          win   = idx;
        end
      end
      if (found && rst) begin
        grant[b][win] = 1'b1;
        bank_en[b]    = 1'b1;
        bank_row[b]   = req_addr[win][AddrW-1:BankW];
        ptrD[b]       = PtrW'((win + 1) % int'(nPORTs));
`ifdef IMEM_BANK_XBAR_MERGE_EN
        // Identical full addresses share the single bank read.
        for (int p = 0; p < int'(nPORTs); p++) begin
          if (req_vld[p] && (req_addr[p] == req_addr[win])) begin
            grant[b][p] = 1'b1;
          end
        end
`endif
      end
    end
  end

  always_comb begin
    req_rdy = '0;
    for (int b = 0; b < int'(nBANKs); b++) begin
      req_rdy = req_rdy | grant[b];
    end
  end

  // Responses steer the bank's read data back while it is valid, otherwise replay the last word.
  always_comb begin
    rsp_vld  = rspVldQ;
    rsp_data = dataHoldQ;
    for (int p = 0; p < int'(nPORTs); p++) begin
      if (rspVldQ[p]) begin
        rsp_data[p] = bank_rdata[rspBankQ[p]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptrQ      <= '0;
      rspVldQ   <= '0;
      rspBankQ  <= '0;
      dataHoldQ <= '0;
    end else begin
      ptrQ      <= ptrD;
      rspVldQ   <= req_rdy;
      dataHoldQ <= rsp_data;
      for (int p = 0; p < int'(nPORTs); p++) begin
        if (req_rdy[p]) begin
          rspBankQ[p] <= req_addr[p][BankW-1:0];
        end
      end
    end
  end

endmodule
